// File: rtl/weighted_aging_pkg.sv
// Shared types and constants for the weighted aging arbiter.
package weighted_aging_pkg;

  typedef enum logic [1:0] {
    AGING       = 2'b00,
    WEIGHTED    = 2'b01,
    ROUND_ROBIN = 2'b10,
    RESERVED    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    GRANT  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  // Queue index width; a two-queue arbiter still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Counter value meaning "just served / never aged", distinct from 0.
  localparam int AGE_RESET = 1;

endpackage

// File: rtl/weighted_aging_arbiter_if.sv
// Queue-status and grant handshake bundle between the queue FIFOs, the
// arbiter (master) and the memory-side dispatcher (slave).
interface weighted_aging_arbiter_if #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32,
  parameter int WEIGHT_SIZE      = 8
);
  localparam int IW = weighted_aging_pkg::idx_width(NUMBER_OF_QUEUES);

  logic [NUMBER_OF_QUEUES-1:0]             empty;
  logic [NUMBER_OF_QUEUES*WEIGHT_SIZE-1:0] weights;
  logic [1:0]                              mode;
  logic                                    grant_valid;
  logic                                    grant_ready;
  logic [IW-1:0]                           selection;
  logic [REGISTER_SIZE-1:0]                selected_age;
  logic [NUMBER_OF_QUEUES-1:0]             saturated;

  modport master (
    input  empty, weights, mode, grant_ready,
    output grant_valid, selection, selected_age, saturated
  );

  modport slave (
    output empty, weights, mode, grant_ready,
    input  grant_valid, selection, selected_age, saturated
  );
endinterface

// File: rtl/aging_max_select.sv
// Combinational pick: oldest non-empty queue with rotating tie-break, or
// first non-empty queue from the start index in round-robin mode.
module aging_max_select
  import weighted_aging_pkg::*;
#(
  parameter int NQ = 4,
  parameter int RS = 32,
  parameter int IW = idx_width(NQ)
) (
  input  logic [NQ-1:0][RS-1:0] age_i,
  input  logic [NQ-1:0]         empty_i,
  input  logic [IW-1:0]         start_i,
  input  logic                  rr_i,
  output logic [IW-1:0]         sel_o,
  output logic                  found_o
);

  int            pos;
  logic [IW-1:0] idx;
  logic [RS-1:0] best;

  // Scan from start_i with wrap; strict '>' keeps the first tied queue.
  always_comb begin
    sel_o   = '0;
    found_o = 1'b0;
    best    = '0;
    pos     = 0;
    idx     = '0;
    for (int k = 0; k < NQ; k++) begin
      pos = int'(start_i) + k;
      if (pos >= NQ) pos = pos - NQ;
      idx = IW'(pos);
      if (!empty_i[idx]) begin
        if (!found_o) begin
          found_o = 1'b1;
          sel_o   = idx;
          best    = age_i[idx];
        end else if (!rr_i && (age_i[idx] > best)) begin
          sel_o = idx;
          best  = age_i[idx];
        end
      end
    end
  end

endmodule

// File: rtl/weighted_aging_arbiter.sv
// Aging scheduler: picks the oldest non-empty queue, holds the grant until
// the dispatcher accepts it (or the queue drains), then ages the others.
module weighted_aging_arbiter
  import weighted_aging_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32,
  parameter int WEIGHT_SIZE      = 8
) (
  input logic clock,
  input logic reset,
  weighted_aging_arbiter_if.master bus
);

  localparam int NQ = NUMBER_OF_QUEUES;
  localparam int RS = REGISTER_SIZE;
  localparam int WS = WEIGHT_SIZE;
  localparam int IW = idx_width(NQ);
  localparam int SW = ((RS > WS) ? RS : WS) + 1;
  localparam logic [RS-1:0] AGE_MAX  = '1;
  localparam logic [RS-1:0] AGE_INIT = RS'(AGE_RESET);

  state_t                state_q, state_d;
  logic [NQ-1:0][RS-1:0] cnt_q, cnt_d;
  logic [NQ-1:0]         sat_q, sat_d;
  logic [IW-1:0]         sel_q, sel_d, last_q, last_d;
  logic [RS-1:0]         age_q, age_d;
  logic [IW-1:0]         start, pick;
  logic                  found;
  mode_t                 mode_s;

  // Add at a width that cannot overflow, then clamp to all-ones.
  function automatic logic [RS-1:0] sat_add(input logic [RS-1:0] a,
                                            input logic [WS-1:0] w);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(w);
    return (s > SW'(AGE_MAX)) ? AGE_MAX : s[RS-1:0];
  endfunction

  assign mode_s = mode_t'(bus.mode);
  assign start  = (last_q == IW'(NQ - 1)) ? '0 : last_q + 1'b1;

  aging_max_select #(.NQ(NQ), .RS(RS), .IW(IW)) u_sel (
    .age_i   (cnt_q),
    .empty_i (bus.empty),
    .start_i (start),
    .rr_i    (mode_s == ROUND_ROBIN),
    .sel_o   (pick),
    .found_o (found)
  );

  // Next-state, grant capture and counter update.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    age_d   = age_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    sat_d   = '0;
    unique case (state_q)
      IDLE: if (~&bus.empty) state_d = SELECT;
      SELECT: begin
        if (found) begin
          sel_d   = pick;
          age_d   = cnt_q[pick];
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Queue drained under us: withdraw, even if ready is also high.
        if (bus.empty[sel_q])     state_d = IDLE;
        else if (bus.grant_ready) state_d = UPDATE;
      end
      UPDATE: begin
        last_d = sel_q;
        for (int q = 0; q < NQ; q++) begin
          if (IW'(q) == sel_q) begin
            cnt_d[q] = AGE_INIT;
          end else if (!bus.empty[q]) begin
            cnt_d[q] = sat_add(cnt_q[q], (mode_s == WEIGHTED) ?
                               bus.weights[q*WS +: WS] : WS'(1));
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    for (int q = 0; q < NQ; q++) sat_d[q] = (cnt_d[q] == AGE_MAX);
  end

  // State, counters and grant registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {NQ{AGE_INIT}};
      sat_q   <= '0;
      sel_q   <= '0;
      last_q  <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      age_q   <= age_d;
    end
  end

  assign bus.grant_valid  = (state_q == GRANT);
  assign bus.selection    = sel_q;
  assign bus.selected_age = age_q;
  assign bus.saturated    = sat_q;

endmodule

// File: tb/tb_weighted_aging_arbiter.sv
// Directed bench for weighted_aging_arbiter: a 32-bit-counter instance and a
// 4-bit-counter instance for clamping.
module tb_weighted_aging_arbiter;
  import weighted_aging_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  weighted_aging_arbiter_if #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(32), .WEIGHT_SIZE(8)) bus ();
  weighted_aging_arbiter_if #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(4),  .WEIGHT_SIZE(8)) bus4 ();

  weighted_aging_arbiter #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(32), .WEIGHT_SIZE(8)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  weighted_aging_arbiter #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(4), .WEIGHT_SIZE(8)) dut4 (
    .clock (clk),
    .reset (rst),
    .bus   (bus4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic wait_gv(input bit wide, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wide ? bus.grant_valid : bus4.grant_valid) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (!ok) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  // Wait for a grant on the 32-bit instance, check it, and take it.
  task automatic grant32(input string tag, input int es, input int ea);
    bit ok;
    wait_gv(1'b1, ok);
    chk({tag, "_sel"}, 32'(bus.selection), es);
    chk({tag, "_age"}, bus.selected_age, ea);
    bus.grant_ready = 1'b1;
    tick(1);
  endtask

  task automatic grant4(input string tag, input int es, input int ea);
    bit ok;
    wait_gv(1'b0, ok);
    chk({tag, "_sel"}, 32'(bus4.selection), es);
    chk({tag, "_age"}, 32'(bus4.selected_age), ea);
    bus4.grant_ready = 1'b1;
    tick(1);
  endtask

  initial begin
    bit ok;
    bus.empty  = 4'hF; bus.weights  = '0; bus.mode  = 2'b00; bus.grant_ready  = 1'b0;
    bus4.empty = 4'hF; bus4.weights = '0; bus4.mode = 2'b00; bus4.grant_ready = 1'b0;

    // Reset values while reset is held.
    rst = 1'b1;
    tick(2);
    chk("rst_gv",  32'(bus.grant_valid), 0);
    chk("rst_sel", 32'(bus.selection), 0);
    chk("rst_age", bus.selected_age, 0);
    chk("rst_sat", 32'(bus.saturated), 0);
    rst = 1'b0;

    // All queues empty: nothing happens.
    tick(10);
    chk("idle_gv",    32'(bus.grant_valid), 0);
    chk("idle_state", 32'(dut.state_q), 32'(IDLE));
    for (int q = 0; q < 4; q++) chk("idle_cnt", dut.cnt_q[q], 1);

    // Plain aging, two-cycle latency, tie rotation from last_selected = 0.
    bus.empty = 4'h0;
    bus.grant_ready = 1'b1;
    tick(1);
    chk("lat_sel_state", 32'(dut.state_q), 32'(SELECT));
    chk("lat_gv_lo",     32'(bus.grant_valid), 0);
    tick(1);
    chk("lat_gv_hi",     32'(bus.grant_valid), 1);
    grant32("age_g0", 1, 1);
    grant32("age_g1", 2, 2);
    grant32("age_g2", 3, 3);
    grant32("age_g3", 0, 4);
    grant32("age_g4", 1, 4);

    // Weighted: queue 3 weight 8, others 1.
    bus.grant_ready = 1'b0;
    bus.empty = 4'hF;
    do_reset();
    bus.mode = 2'b01;
    bus.weights = {8'd8, 8'd1, 8'd1, 8'd1};
    bus.empty = 4'h0;
    bus.grant_ready = 1'b1;
    grant32("wt_g0", 1, 1);
    grant32("wt_g1", 3, 9);
    tick(1);
    chk("wt_served_cnt", dut.cnt_q[3], 1);
    grant32("wt_g2", 0, 3);
    grant32("wt_g3", 3, 9);
    grant32("wt_g4", 2, 5);
    grant32("wt_g5", 3, 9);

    // Revoke with simultaneous ready: revoke wins, counters untouched.
    bus.grant_ready = 1'b0;
    bus.empty = 4'hF;
    do_reset();
    bus.mode = 2'b00;
    bus.empty = 4'b1011;
    wait_gv(1'b1, ok);
    chk("rev_sel", 32'(bus.selection), 2);
    chk("rev_age", bus.selected_age, 1);
    tick(2);
    chk("rev_hold_gv", 32'(bus.grant_valid), 1);
    bus.empty = 4'b0100;
    bus.grant_ready = 1'b1;
    tick(1);
    chk("rev_gv",    32'(bus.grant_valid), 0);
    chk("rev_state", 32'(dut.state_q), 32'(IDLE));
    tick(1);
    for (int q = 0; q < 4; q++) chk("rev_cnt", dut.cnt_q[q], 1);
    grant32("rev_reselect", 1, 1);

    // Round-robin over queues 1 and 3.
    bus.grant_ready = 1'b0;
    bus.empty = 4'hF;
    do_reset();
    bus.mode = 2'b10;
    bus.empty = 4'b0101;
    bus.grant_ready = 1'b1;
    grant32("rr_g0", 1, 1);
    grant32("rr_g1", 3, 2);
    grant32("rr_g2", 1, 2);
    grant32("rr_g3", 3, 2);

    // Reset during GRANT drops grant_valid without a clock edge.
    bus.grant_ready = 1'b0;
    wait_gv(1'b1, ok);
    rst = 1'b1;
    #1;
    chk("rst_mid_gv", 32'(bus.grant_valid), 0);
    tick(1);
    bus.empty = 4'hF;
    rst = 1'b0;
    tick(1);

    // Clamping on the 4-bit instance: queue 0 is never served before it saturates.
    bus4.mode = 2'b01;
    bus4.weights = {8'd15, 8'd0, 8'd0, 8'd15};
    bus4.empty = 4'b0110;
    bus4.grant_ready = 1'b1;
    grant4("sat_g0", 3, 1);
    tick(1);
    chk("sat_cnt0", 32'(dut4.cnt_q[0]), 15);
    chk("sat_flag0", 32'(bus4.saturated), 32'b0001);
    grant4("sat_g1", 0, 15);
    tick(1);
    chk("sat_flag1", 32'(bus4.saturated), 32'b1000);
    grant4("sat_g2", 3, 15);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
